// File: rtl/bullet_ctrl_pkg.sv
// Shared game constants: controller state encoding, screen geometry, park row
// and the airplane band that the collision checker tests against.
package bullet_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LAUNCH   = 3'd1;
  localparam logic [2:0] ST_FLYING   = 3'd2;
  localparam logic [2:0] ST_HIT      = 3'd3;
  localparam logic [2:0] ST_COOLDOWN = 3'd4;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int GAME_PARK_Y = 1023;

  // Airplane row centre and half-height of the band the checker compares against.
  localparam int PLANE_Y    = 60;
  localparam int PLANE_BAND = 10;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous push button followed by a
// rising-edge detector; a held button produces a single one-clk pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], btn};
    end
  end

  // sync[1] is the metastability-safe level; sync[2] is its previous value.
  assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/bullet_ctrl.sv
// Bullet controller: fires from the cannon, climbs one STEP per frame, retires
// on a collision (explosion + score) or at the top of the screen (miss).
module bullet_ctrl
  import bullet_ctrl_pkg::*;
#(
  parameter int START_Y         = 440,
  parameter int STEP            = 4,
  parameter int X_OFFSET        = 15,
  parameter int X_MAX           = SCREEN_W - 1,
  parameter int PARK_Y          = GAME_PARK_Y,
  parameter int HIT_FRAMES      = 15,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int GUARD_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire_btn,
  input  logic [9:0] cannon_x,
  input  logic       col,
  output logic [9:0] bulletx,
  output logic [9:0] bullety,
  output logic       bullet_active,
  output logic       exploding,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score
);

  localparam logic [9:0] START_Y_V  = 10'(START_Y);
  localparam logic [9:0] STEP_V     = 10'(STEP);
  localparam logic [9:0] PARK_Y_V   = 10'(PARK_Y);
  localparam logic [4:0] HIT_LAST   = 5'(HIT_FRAMES - 1);
  localparam logic [4:0] COOL_LAST  = 5'(COOLDOWN_FRAMES - 1);
  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES);

  logic [2:0] state;
  logic [3:0] guard;
  logic [4:0] frame_cnt;
  logic       fire_rise;

  function automatic logic [9:0] sat_launch_x(input logic [9:0] cx);
    logic [10:0] sum;
    sum = {1'b0, cx} + 11'(X_OFFSET);
    if (sum > 11'(X_MAX)) return 10'(X_MAX);
    return sum[9:0];
  endfunction

  function automatic logic [7:0] sat_inc_score(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  btn_sync_edge u_fire_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (fire_btn),
    .rise  (fire_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bulletx       <= 10'd0;
      bullety       <= PARK_Y_V;
      bullet_active <= 1'b0;
      exploding     <= 1'b0;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
      score         <= 8'd0;
      guard         <= 4'd0;
      frame_cnt     <= 5'd0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fire_rise) state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          bulletx       <= sat_launch_x(cannon_x);
          bullety       <= START_Y_V;
          guard         <= GUARD_INIT;
          bullet_active <= 1'b1;
          state         <= ST_FLYING;
        end
        ST_FLYING: begin
          if (guard != 4'd0) guard <= guard - 4'd1;
          // A hit wins over a same-cycle frame tick so the sprite shows the hit row.
          if (col && guard == 4'd0) begin
            state         <= ST_HIT;
            hit_pulse     <= 1'b1;
            score         <= sat_inc_score(score);
            bullet_active <= 1'b0;
            exploding     <= 1'b1;
            frame_cnt     <= 5'd0;
          end else if (frame_tick) begin
            if (bullety < STEP_V) begin
              state         <= ST_COOLDOWN;
              miss_pulse    <= 1'b1;
              bullet_active <= 1'b0;
              bulletx       <= 10'd0;
              bullety       <= PARK_Y_V;
              frame_cnt     <= 5'd0;
            end else begin
              bullety <= bullety - STEP_V;
            end
          end
        end
        ST_HIT: begin
          if (frame_tick) begin
            if (frame_cnt == HIT_LAST) begin
              state     <= ST_COOLDOWN;
              exploding <= 1'b0;
              bulletx   <= 10'd0;
              bullety   <= PARK_Y_V;
              frame_cnt <= 5'd0;
            end else begin
              frame_cnt <= frame_cnt + 5'd1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (frame_tick) begin
            if (frame_cnt == COOL_LAST) begin
              state     <= ST_IDLE;
              frame_cnt <= 5'd0;
            end else begin
              frame_cnt <= frame_cnt + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl: launch, climb, miss, hit, guard window,
// fire blocking, held button, x saturation, async reset and score saturation.
module tb_bullet_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       fire_btn = 1'b0;
  logic [9:0] cannon_x = 10'd0;
  logic       col = 1'b0;
  logic [9:0] bulletx;
  logic [9:0] bullety;
  logic       bullet_active;
  logic       exploding;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] score;

  int pass_cnt = 0;
  int total_cnt = 0;
  int launch_cnt = 0;
  logic act_q = 1'b0;

  bullet_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .fire_btn      (fire_btn),
    .cannon_x      (cannon_x),
    .col           (col),
    .bulletx       (bulletx),
    .bullety       (bullety),
    .bullet_active (bullet_active),
    .exploding     (exploding),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .score         (score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bullet_active && !act_q) launch_cnt <= launch_cnt + 1;
    act_q <= bullet_active;
  end

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press_launch(output bit ok);
    ok = 1'b0;
    fire_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bullet_active) begin
        ok = 1'b1;
        break;
      end
    end
    fire_btn = 1'b0;
  endtask

  task automatic press_blocked();
    fire_btn = 1'b1;
    repeat (6) @(negedge clk);
    fire_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic quick_hit(input logic [9:0] cx, output bit ok, output logic [9:0] bx);
    cannon_x = cx;
    press_launch(ok);
    bx = bulletx;
    repeat (3) @(negedge clk);
    col = 1'b1;
    @(negedge clk) col = 1'b0;
    ticks(23);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total_cnt++; if (bullety !== 10'd1023) $display("FAIL reset_y: got %0d expected 1023", bullety); else pass_cnt++;
    total_cnt++; if (bulletx !== 10'd0) $display("FAIL reset_x: got %0d expected 0", bulletx); else pass_cnt++;
    total_cnt++; if ({bullet_active, exploding, hit_pulse, miss_pulse} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {bullet_active, exploding, hit_pulse, miss_pulse}); else pass_cnt++;
    total_cnt++; if (score !== 8'd0) $display("FAIL reset_score: got %0d expected 0", score); else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Ends with a freshly launched bullet from cannon_x=90 still in flight.
  task automatic test_miss();
    bit ok;
    cannon_x = 10'd90;
    press_launch(ok);
    total_cnt++; if (!ok) $display("FAIL miss_launch: got no launch expected launch"); else pass_cnt++;
    total_cnt++; if (bulletx !== 10'd105) $display("FAIL miss_x0: got %0d expected 105", bulletx); else pass_cnt++;
    total_cnt++; if (bullety !== 10'd440) $display("FAIL miss_y0: got %0d expected 440", bullety); else pass_cnt++;
    ticks(110);
    total_cnt++; if (bullety !== 10'd0 || bullet_active !== 1'b1)
      $display("FAIL miss_top: got y=%0d act=%b expected y=0 act=1", bullety, bullet_active); else pass_cnt++;
    tick();
    total_cnt++; if (miss_pulse !== 1'b1) $display("FAIL miss_pulse: got %b expected 1", miss_pulse); else pass_cnt++;
    total_cnt++; if (bullety !== 10'd1023 || bulletx !== 10'd0 || bullet_active !== 1'b0)
      $display("FAIL miss_park: got x=%0d y=%0d act=%b expected x=0 y=1023 act=0", bulletx, bullety, bullet_active); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (miss_pulse !== 1'b0) $display("FAIL miss_pulse_len: got %b expected 0", miss_pulse); else pass_cnt++;
    ticks(7);
    press_blocked();
    total_cnt++; if (bullet_active !== 1'b0) $display("FAIL cool_block: got act=%b expected 0", bullet_active); else pass_cnt++;
    tick();
    press_launch(ok);
    total_cnt++; if (!ok) $display("FAIL cool_idle: got no launch expected launch after 8 ticks"); else pass_cnt++;
  endtask

  task automatic test_hit();
    ticks(93);
    total_cnt++; if (bullety !== 10'd68 || bulletx !== 10'd105)
      $display("FAIL hit_pos: got x=%0d y=%0d expected x=105 y=68", bulletx, bullety); else pass_cnt++;
    col = 1'b1;
    @(negedge clk) col = 1'b0;
    total_cnt++; if (hit_pulse !== 1'b1) $display("FAIL hit_pulse: got %b expected 1", hit_pulse); else pass_cnt++;
    total_cnt++; if (score !== 8'd1) $display("FAIL hit_score: got %0d expected 1", score); else pass_cnt++;
    total_cnt++; if (exploding !== 1'b1 || bullet_active !== 1'b0 || bullety !== 10'd68)
      $display("FAIL hit_state: got exp=%b act=%b y=%0d expected exp=1 act=0 y=68", exploding, bullet_active, bullety); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (hit_pulse !== 1'b0) $display("FAIL hit_pulse_len: got %b expected 0", hit_pulse); else pass_cnt++;
    press_blocked();
    total_cnt++; if (bullet_active !== 1'b0 || exploding !== 1'b1)
      $display("FAIL hit_block: got act=%b exp=%b expected act=0 exp=1", bullet_active, exploding); else pass_cnt++;
    ticks(14);
    total_cnt++; if (exploding !== 1'b1) $display("FAIL explode_14: got %b expected 1", exploding); else pass_cnt++;
    tick();
    total_cnt++; if (exploding !== 1'b0 || bullety !== 10'd1023)
      $display("FAIL explode_end: got exp=%b y=%0d expected exp=0 y=1023", exploding, bullety); else pass_cnt++;
    ticks(8);
  endtask

  task automatic test_simultaneous();
    bit ok;
    cannon_x = 10'd200;
    press_launch(ok);
    repeat (3) @(negedge clk);
    col = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    col = 1'b0;
    frame_tick = 1'b0;
    total_cnt++; if (!ok || hit_pulse !== 1'b1 || bullety !== 10'd440 || bulletx !== 10'd215)
      $display("FAIL simul: got ok=%b hit=%b x=%0d y=%0d expected ok=1 hit=1 x=215 y=440", ok, hit_pulse, bulletx, bullety); else pass_cnt++;
    total_cnt++; if (score !== 8'd2) $display("FAIL simul_score: got %0d expected 2", score); else pass_cnt++;
    ticks(23);
  endtask

  task automatic test_guard();
    bit ok;
    cannon_x = 10'd0;
    press_launch(ok);
    col = 1'b1;
    @(negedge clk);
    total_cnt++; if (bullet_active !== 1'b1 || hit_pulse !== 1'b0)
      $display("FAIL guard_1: got act=%b hit=%b expected act=1 hit=0", bullet_active, hit_pulse); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bullet_active !== 1'b1 || hit_pulse !== 1'b0)
      $display("FAIL guard_2: got act=%b hit=%b expected act=1 hit=0", bullet_active, hit_pulse); else pass_cnt++;
    @(negedge clk) col = 1'b0;
    total_cnt++; if (!ok || hit_pulse !== 1'b1 || bulletx !== 10'd15 || score !== 8'd3)
      $display("FAIL guard_open: got ok=%b hit=%b x=%0d score=%0d expected ok=1 hit=1 x=15 score=3", ok, hit_pulse, bulletx, score); else pass_cnt++;
    ticks(23);
  endtask

  task automatic test_held();
    int base;
    bit seen;
    base = launch_cnt;
    seen = 1'b0;
    cannon_x = 10'd300;
    fire_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bullet_active) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    col = 1'b1;
    @(negedge clk) col = 1'b0;
    ticks(23);
    repeat (940) @(negedge clk);
    total_cnt++; if (!seen || bullet_active !== 1'b0 || launch_cnt - base !== 1)
      $display("FAIL held_once: got seen=%b act=%b launches=%0d expected seen=1 act=0 launches=1", seen, bullet_active, launch_cnt - base); else pass_cnt++;
    fire_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_sat_x();
    bit ok;
    logic [9:0] bx;
    quick_hit(10'd630, ok, bx);
    total_cnt++; if (!ok || bx !== 10'd639) $display("FAIL sat_630: got ok=%b x=%0d expected 639", ok, bx); else pass_cnt++;
    quick_hit(10'd623, ok, bx);
    total_cnt++; if (!ok || bx !== 10'd638) $display("FAIL sat_623: got ok=%b x=%0d expected 638", ok, bx); else pass_cnt++;
    quick_hit(10'd1023, ok, bx);
    total_cnt++; if (!ok || bx !== 10'd639) $display("FAIL sat_1023: got ok=%b x=%0d expected 639", ok, bx); else pass_cnt++;
    total_cnt++; if (score !== 8'd7) $display("FAIL sat_score: got %0d expected 7", score); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    bit ok;
    cannon_x = 10'd90;
    press_launch(ok);
    ticks(60);
    total_cnt++; if (!ok || bullety !== 10'd200) $display("FAIL mid_y: got ok=%b y=%0d expected y=200", ok, bullety); else pass_cnt++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (bullety !== 10'd1023 || bullet_active !== 1'b0 || score !== 8'd0 || bulletx !== 10'd0)
      $display("FAIL mid_reset: got x=%0d y=%0d act=%b score=%0d expected x=0 y=1023 act=0 score=0", bulletx, bullety, bullet_active, score); else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_score_sat();
    bit ok;
    logic [9:0] bx;
    int timeouts;
    timeouts = 0;
    for (int i = 0; i < 255; i++) begin
      quick_hit(10'd100, ok, bx);
      if (!ok) timeouts++;
    end
    total_cnt++; if (score !== 8'd255) $display("FAIL score_255: got %0d expected 255", score); else pass_cnt++;
    for (int i = 0; i < 256; i++) begin
      quick_hit(10'd100, ok, bx);
      if (!ok) timeouts++;
    end
    total_cnt++; if (score !== 8'd255) $display("FAIL score_hold: got %0d expected 255", score); else pass_cnt++;
    total_cnt++; if (timeouts !== 0) $display("FAIL score_launches: got %0d timeouts expected 0", timeouts); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_simultaneous();
    test_guard();
    test_held();
    test_sat_x();
    test_reset_midflight();
    test_score_sat();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
